store_buffer: RTL

Store-side counterpart of the load data extractor (outData). It accepts store requests from the datapath, replicates the store data into the correct big-endian byte lanes, and generates the 4-bit byte-enable mask for the target word. Requests are queued in a 2-entry FIFO and drained to data memory over a valid/ack handshake. Misaligned or reserved-size stores are consumed and dropped, with a one-cycle error pulse. Sits between the MEM stage and the data memory write port.

---
 rtl/store_buffer.sv | 110 +++++++++++
 1 files changed

// File: rtl/store_buffer.sv
// Store buffer: formats store data into big-endian byte lanes with byte enables,
// queues up to two writes and drains them to data memory over a valid/ack handshake.
module store_buffer (
  input  logic        clk,
  input  logic        reset,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [0:31] st_addr,
  input  logic [0:31] st_data,
  input  logic [0:1]  DSize,
  output logic        mem_wr,
  output logic [0:31] mem_addr,
  output logic [0:31] mem_wdata,
  output logic [0:3]  mem_be,
  input  logic        mem_ack,
  output logic        misalign,
  output logic [0:1]  count
);

  logic [0:31] addrMem [2];
  logic [0:31] dataMem [2];
  logic [0:3]  beMem   [2];
  logic        rdPtr;
  logic        wrPtr;

  logic [0:31] fmtData;
  logic [0:3]  fmtBe;
  logic        drop;
  logic        accept;
  logic        push;
  logic        pop;

  // Lane replication and byte-enable generation; be[0] is the lowest byte address.
  always_comb begin
    fmtData = st_data;
    fmtBe   = 4'b0000;
    drop    = 1'b0;
    case (DSize)
      2'd0: begin
        fmtData = {4{st_data[24:31]}};
        fmtBe   = 4'b1000 >> st_addr[30:31];
      end
      2'd1: begin
        fmtData = {2{st_data[16:31]}};
        fmtBe   = st_addr[30] ? 4'b0011 : 4'b1100;
        drop    = st_addr[31];
      end
      2'd3: begin
        fmtData = st_data;
        fmtBe   = 4'b1111;
        drop    = (st_addr[30:31] != 2'b00);
      end
      default: begin
        drop = 1'b1;
      end
    endcase
  end

  // Dropped stores still complete the handshake but never occupy an entry.
  always_comb begin
    st_ready = (count != 2'd2);
    mem_wr   = (count != 2'd0);
    accept   = st_valid && st_ready;
    push     = accept && !drop;
    pop      = mem_wr && mem_ack;
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if (mem_wr) begin
      mem_addr  = addrMem[rdPtr];
      mem_wdata = dataMem[rdPtr];
      mem_be    = beMem[rdPtr];
    end
  end

  // Entry storage needs no reset: the outputs are masked whenever count is 0.
  always_ff @(posedge clk) begin
    if (push) begin
      addrMem[wrPtr] <= {st_addr[0:29], 2'b00};
      dataMem[wrPtr] <= fmtData;
      beMem[wrPtr]   <= fmtBe;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count    <= 2'd0;
      rdPtr    <= 1'b0;
      wrPtr    <= 1'b0;
      misalign <= 1'b0;
    end else begin
      misalign <= accept && drop;
      if (push) begin
        wrPtr <= ~wrPtr;
      end
      if (pop) begin
        rdPtr <= ~rdPtr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule
